mod461_residue_accum: RTL



---
 rtl/mod461_residue_accum.sv | 110 +++++++++++
 1 files changed

// File: rtl/mod461_residue_accum.sv
// Streaming accumulator: sums W-bit partial residues into one residue mod MODULUS per frame.
// Define MOD461_COUNT_CHECK_EN to build the beat counter that flags frames whose length differs from TERMS.
module mod461_residue_accum #(
   parameter int unsigned MODULUS = 461,
   parameter int unsigned W       = 9,
   parameter int unsigned TERMS   = 34
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   input  logic         in_last,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data,
   output logic         out_err
);

   localparam logic [W:0] MOD_W = (W+1)'(MODULUS);

   typedef enum logic {S_ACC, S_DONE} state_t;

   state_t       state_q;
   logic [W-1:0] acc_q;
   logic [W-1:0] out_data_q;
   logic         out_valid_q;
   logic         accept;
   logic [W:0]   sum_d;
   logic [W-1:0] res_d;

   // acc < MODULUS and in_data < 2^W keep the sum below 3*MODULUS, so two subtractions reduce fully.
   function automatic logic [W-1:0] reduce_mod(input logic [W:0] sum);
      logic [W:0] r1;
      logic [W:0] r2;
      r1 = (sum >= MOD_W) ? (sum - MOD_W) : sum;
      r2 = (r1 >= MOD_W) ? (r1 - MOD_W) : r1;
      return r2[W-1:0];
   endfunction

   assign in_ready = (state_q == S_ACC) && !rst;
   assign accept   = in_valid && in_ready;

   always_comb begin
      sum_d = {1'b0, acc_q} + {1'b0, in_data};
      res_d = reduce_mod(sum_d);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_ACC;
         acc_q       <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
      end else begin
         case (state_q)
            S_ACC: begin
               if (accept) begin
                  if (in_last) begin
                     out_data_q  <= res_d;
                     out_valid_q <= 1'b1;
                     acc_q       <= '0;
                     state_q     <= S_DONE;
                  end else begin
                     acc_q <= res_d;
                  end
               end
            end
            S_DONE: begin
               if (out_valid_q && out_ready) begin
                  out_valid_q <= 1'b0;
                  state_q     <= S_ACC;
               end
            end
            default: state_q <= S_ACC;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;

`ifdef MOD461_COUNT_CHECK_EN
   logic [5:0] cnt_q;
   logic       err_q;
   logic [6:0] cnt_inc_d;

   assign cnt_inc_d = {1'b0, cnt_q} + 7'd1;

   // Counter saturates so that overlong frames cannot wrap back to a matching count.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else if (accept) begin
         if (in_last) begin
            err_q <= (cnt_inc_d != 7'(TERMS));
            cnt_q <= '0;
         end else if (cnt_q != 6'd63) begin
            cnt_q <= cnt_inc_d[5:0];
         end
      end
   end

   assign out_err = err_q;
`else
   assign out_err = 1'b0;
`endif

endmodule
